// File: rtl/srl_chain_fifo_ctrl_if.sv
// Stream and SRL-chain signals of srl_chain_fifo_ctrl; the controller takes the slave side.
interface srl_chain_fifo_ctrl_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic               srl_ce;
    logic [WIDTH-1:0]   srl_d;
    logic [4:0]         srl_a;
    logic [3*WIDTH-1:0] srl_q;
    logic [6:0]         level;

    modport slave (
        input  in_data, in_valid, out_ready, srl_q,
        output in_ready, out_data, out_valid, srl_ce, srl_d, srl_a, level
    );

    modport master (
        output in_data, in_valid, out_ready, srl_q,
        input  in_ready, out_data, out_valid, srl_ce, srl_d, srl_a, level
    );
endinterface

// File: rtl/srl_chain_fifo_ctrl.sv
// Valid/ready FIFO controller around an external D6->C6->B6 SRLC32E cascade per data bit,
// with a registered output word in front of the consumer.
module srl_chain_fifo_ctrl #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 96
) (
    input  logic                 clk,
    input  logic                 rst_n,
    srl_chain_fifo_ctrl_if.slave bus
);
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned A_W     = 5;
    localparam int unsigned STAGES  = 3;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             ov;
    logic             ov_next;
    logic [WIDTH-1:0] odata;
    logic [WIDTH-1:0] odata_next;
    logic [CNT_W-1:0] idx;
    logic [1:0]       sel;
    logic [WIDTH-1:0] rd;
    logic             push;
    logic             load;

    // Oldest entry position, decoded from the registered occupancy only
    always_comb begin
        idx = '0;
        if (cnt != '0) begin
            idx = cnt - CNT_W'(1);
        end
    end

    assign sel        = idx[CNT_W-1:A_W];
    assign bus.srl_a  = idx[A_W-1:0];

    // Asynchronous read: pick the chain stage holding the oldest entry for every bit
    always_comb begin
        rd = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            rd[i] = bus.srl_q[STAGES*i + 32'(sel)];
        end
    end

    // Writes are gated by reset so a held in_valid cannot shift the chain during reset
    assign bus.in_ready = (cnt < CNT_W'(DEPTH));
    assign push         = rst_n & bus.in_valid & bus.in_ready;
    assign load         = (cnt != '0) & (~ov | bus.out_ready);

    assign bus.srl_ce    = push;
    assign bus.srl_d     = bus.in_data;
    assign bus.out_data  = odata;
    assign bus.out_valid = ov;
    assign bus.level     = cnt + CNT_W'(ov);

    always_comb begin
        cnt_next   = cnt;
        ov_next    = ov;
        odata_next = odata;
        if (load) begin
            odata_next = rd;
            ov_next    = 1'b1;
        end else if (bus.out_ready && ov) begin
            ov_next    = 1'b0;
        end
        cnt_next = cnt + CNT_W'(push) - CNT_W'(load);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            ov    <= 1'b0;
            odata <= '0;
        end else begin
            cnt   <= cnt_next;
            ov    <= ov_next;
            odata <= odata_next;
        end
    end
endmodule

// File: tb/tb_srl_chain_fifo_ctrl.sv
// Bench for srl_chain_fifo_ctrl: behavioural SRL cascade, directed vector table,
// queue scoreboard and corner-case sequences on a DEPTH=96 and a DEPTH=20 instance.
module tb_srl_chain_fifo_ctrl;
    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    srl_chain_fifo_ctrl_if #(.WIDTH(WIDTH)) bus ();
    srl_chain_fifo_ctrl_if #(.WIDTH(WIDTH)) bus20 ();

    srl_chain_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(96)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    srl_chain_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(20)) dut20 (.clk(clk), .rst_n(rst_n), .bus(bus20));

    // Behavioural SRLC32E cascade: position p = 32*stage + address
    logic [WIDTH-1:0] mem   [96];
    logic [WIDTH-1:0] mem20 [96];

    always @(posedge clk) begin
        if (bus.srl_ce) begin
            for (int p = 95; p > 0; p--) mem[p] <= mem[p-1];
            mem[0] <= bus.srl_d;
        end
        if (bus20.srl_ce) begin
            for (int p = 95; p > 0; p--) mem20[p] <= mem20[p-1];
            mem20[0] <= bus20.srl_d;
        end
    end

    always_comb begin
        bus.srl_q   = '0;
        bus20.srl_q = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            for (int s = 0; s < 3; s++) begin
                bus.srl_q[3*i+s]   = mem[32*s + int'(bus.srl_a)][i];
                bus20.srl_q[3*i+s] = mem20[32*s + int'(bus20.srl_a)][i];
            end
        end
    end

    int passed = 0;
    int total  = 0;
    logic [WIDTH-1:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle on the 96-deep instance; inputs settle mid-cycle, scoreboard tracks the coming edge
    task automatic step(input logic r, input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
        logic [WIDTH-1:0] exp;
        @(negedge clk);
        rst_n         = r;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        if (r && bus.out_valid && ordy) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(bus.out_data), 32'hFFFF_FFFF);
            end else begin
                exp = sb.pop_front();
                chk("sb_data", 32'(bus.out_data), 32'(exp));
            end
        end
        if (r && iv && bus.in_ready) sb.push_back(d);
        if (!r) sb.delete();
    endtask

    task automatic step20(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
        @(negedge clk);
        bus20.in_valid  = iv;
        bus20.in_data   = d;
        bus20.out_ready = ordy;
        #1;
    endtask

    task automatic check_addr(input string name, input int c);
        int idx;
        idx = (c > 0) ? c - 1 : 0;
        chk({name, "_a"},   32'(bus.srl_a), 32'(idx % 32));
        chk({name, "_sel"}, 32'(dut.sel),   32'(idx / 32));
    endtask

    // Drain with the consumer always ready; ecnt tracks expected SRL occupancy for address checks
    task automatic drain(input int ecnt_in, input logic addr_chk);
        int n;
        int ecnt;
        n    = 0;
        ecnt = ecnt_in;
        while (sb.size() != 0 && n < 400) begin
            step(1'b1, 1'b0, '0, 1'b1);
            if (addr_chk) check_addr("drain", ecnt);
            if (ecnt > 0) ecnt--;
            n++;
        end
        chk("drain_done", 32'(sb.size()), 32'd0);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("drain_level", 32'(bus.level), 32'd0);
        chk("drain_ov", 32'(bus.out_valid), 32'd0);
    endtask

    typedef struct {
        logic             rst_n;
        logic             iv;
        logic [WIDTH-1:0] d;
        logic             ordy;
        logic             e_rdy;
        logic             e_ov;
        logic [WIDTH-1:0] e_data;
        logic [6:0]       e_lvl;
        logic             e_ce;
        logic [4:0]       e_a;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int nxt;
        int k;
        // rst, iv, d, ordy | rdy, ov, data, level, ce, a
        tbl[0]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 7'd0, 1'b0, 5'd0};
        tbl[1]  = '{1'b0, 1'b1, 8'h56, 1'b0, 1'b1, 1'b0, 8'h00, 7'd0, 1'b0, 5'd0};
        tbl[2]  = '{1'b0, 1'b1, 8'h57, 1'b1, 1'b1, 1'b0, 8'h00, 7'd0, 1'b0, 5'd0};
        tbl[3]  = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 8'h00, 7'd0, 1'b1, 5'd0};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 7'd1, 1'b0, 5'd0};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 7'd1, 1'b0, 5'd0};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 7'd0, 1'b0, 5'd0};
        tbl[7]  = '{1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 8'h01, 7'd0, 1'b1, 5'd0};
        tbl[8]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h01, 7'd1, 1'b1, 5'd0};
        tbl[9]  = '{1'b1, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 8'h10, 7'd2, 1'b1, 5'd0};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h10, 7'd3, 1'b0, 5'd1};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h10, 7'd3, 1'b0, 5'd1};
        tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 7'd2, 1'b0, 5'd0};
        tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h12, 7'd1, 1'b0, 5'd0};
        tbl[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h12, 7'd0, 1'b0, 5'd0};

        bus.in_valid    = 1'b1;
        bus.in_data     = '0;
        bus.out_ready   = 1'b0;
        bus20.in_valid  = 1'b0;
        bus20.in_data   = '0;
        bus20.out_ready = 1'b0;
        rst_n           = 1'b0;
        @(posedge clk);

        // Reset, single-word latency and a small push/pop mix
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].rst_n, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk($sformatf("v%0d_in_ready", i),  32'(bus.in_ready),  32'(tbl[i].e_rdy));
            chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("v%0d_out_data", i),  32'(bus.out_data),  32'(tbl[i].e_data));
            chk($sformatf("v%0d_level", i),     32'(bus.level),     32'(tbl[i].e_lvl));
            chk($sformatf("v%0d_srl_ce", i),    32'(bus.srl_ce),    32'(tbl[i].e_ce));
            chk($sformatf("v%0d_srl_a", i),     32'(bus.srl_a),     32'(tbl[i].e_a));
        end

        // Fill to full: 97 words (96 in the chain plus the output register), crossing both stages
        for (int i = 0; i <= 96; i++) begin
            step(1'b1, 1'b1, 8'(i), 1'b0);
            chk("fill_in_ready", 32'(bus.in_ready), 32'd1);
            check_addr("fill", (i == 0) ? 0 : i - 1);
        end
        step(1'b1, 1'b0, '0, 1'b0);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_level", 32'(bus.level), 32'd97);
        chk("full_srl_a", 32'(bus.srl_a), 32'd31);
        chk("full_sel", 32'(dut.sel), 32'd2);
        // A load at full does not open the input in the same cycle
        step(1'b1, 1'b1, 8'hEE, 1'b1);
        chk("full_pop_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_pop_srl_ce", 32'(bus.srl_ce), 32'd0);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("after_pop_in_ready", 32'(bus.in_ready), 32'd1);
        chk("after_pop_level", 32'(bus.level), 32'd96);
        drain(95, 1'b1);

        // Stage boundary: 34 words leave cnt=33, then drain across the 33->32 crossing
        for (int i = 0; i < 34; i++) step(1'b1, 1'b1, 8'(8'hA0 + i), 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("b33_level", 32'(bus.level), 32'd34);
        chk("b33_srl_a", 32'(bus.srl_a), 32'd0);
        chk("b33_sel", 32'(dut.sel), 32'd1);
        drain(33, 1'b1);

        // Streaming with independent random valid/ready patterns
        for (int i = 0; i < 10000; i++) begin
            step(1'b1, 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        drain(0, 1'b0);

        // Reset mid-stream at cnt=50 discards everything; the next push is the next word out
        for (int i = 0; i < 51; i++) step(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("mid_level", 32'(bus.level), 32'd51);
        step(1'b0, 1'b1, 8'h77, 1'b0);
        chk("mid_rst_srl_ce", 32'(bus.srl_ce), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        step(1'b1, 1'b1, 8'h0A, 1'b0);
        chk("post_rst_level", 32'(bus.level), 32'd0);
        chk("post_rst_ov", 32'(bus.out_valid), 32'd0);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        chk("post_rst_ov2", 32'(bus.out_valid), 32'd1);
        chk("post_rst_data", 32'(bus.out_data), 32'h0A);
        drain(0, 1'b0);

        // DEPTH=20 instance: full at cnt=20, stage select never leaves 0
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            step20(1'b1, 8'(8'hC0 + i), 1'b0);
            chk("d20_fill_in_ready", 32'(bus20.in_ready), 32'd1);
            chk("d20_fill_sel", 32'(dut20.sel), 32'd0);
        end
        step20(1'b0, '0, 1'b0);
        chk("d20_full_in_ready", 32'(bus20.in_ready), 32'd0);
        chk("d20_full_level", 32'(bus20.level), 32'd21);
        chk("d20_full_srl_a", 32'(bus20.srl_a), 32'd19);
        chk("d20_full_sel", 32'(dut20.sel), 32'd0);
        nxt = 0;
        k   = 0;
        while (nxt < 21 && k < 60) begin
            step20(1'b0, '0, 1'b1);
            chk("d20_drain_sel", 32'(dut20.sel), 32'd0);
            if (bus20.out_valid) begin
                chk("d20_drain_data", 32'(bus20.out_data), 32'(8'hC0 + nxt));
                nxt++;
            end
            k++;
        end
        chk("d20_drain_count", 32'(nxt), 32'd21);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
